// File: rtl/bp_update_sched.sv
// Branch-predictor update scheduler: merges two execute-stage training ports into an
// in-order circular FIFO and drains it one entry per cycle into the predictor write port.
module bp_update_sched #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     squash,
    input  logic                     in0_valid,
    input  logic [XLEN-1:0]          in0_pc,
    input  logic [XLEN-1:0]          in0_tg_pc,
    input  logic                     in0_taken,
    input  logic                     in0_cond,
    input  logic                     in1_valid,
    input  logic [XLEN-1:0]          in1_pc,
    input  logic [XLEN-1:0]          in1_tg_pc,
    input  logic                     in1_taken,
    input  logic                     in1_cond,
    output logic                     in_ready,
    output logic                     upd_valid,
    input  logic                     upd_ready,
    output logic [XLEN-1:0]          upd_pc,
    output logic [XLEN-1:0]          upd_tg_pc,
    output logic                     upd_taken,
    output logic                     upd_cond,
    output logic [$clog2(DEPTH):0]   count,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = CNT_W + 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] tg_pc;
        logic            taken;
        logic            cond;
    } entry_t;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             in_ready_q, in_ready_d;

    logic             deq;
    logic             acc0, acc1;
    logic [CW-1:0]    free, free_after0;
    logic [PW-1:0]    wr1_idx;
    logic [1:0]       drops;
    logic [DW-1:0]    drop_sum;

    // Handshake: an entry leaves the head on a cycle where upd_valid && upd_ready;
    // while upd_valid && !upd_ready the head entry (and so upd_*) is held unchanged.
    always_comb begin
        deq         = (count_q != '0) && upd_ready;
        free        = CW'(DEPTH) - count_q + CW'(deq);
        acc0        = in0_valid && (free != '0);
        free_after0 = free - CW'(acc0);
        acc1        = in1_valid && (free_after0 != '0);
        drops       = {1'b0, in0_valid & ~acc0} + {1'b0, in1_valid & ~acc1};
        wr1_idx     = wr_ptr_q + PW'(acc0);

        mem_d = mem_q;
        if (acc0) mem_d[wr_ptr_q] = '{pc: in0_pc, tg_pc: in0_tg_pc, taken: in0_taken, cond: in0_cond};
        if (acc1) mem_d[wr1_idx]  = '{pc: in1_pc, tg_pc: in1_tg_pc, taken: in1_taken, cond: in1_cond};

        rd_ptr_d   = rd_ptr_q + PW'(deq);
        wr_ptr_d   = wr_ptr_q + PW'(acc0) + PW'(acc1);
        count_d    = count_q + CW'(acc0) + CW'(acc1) - CW'(deq);
        drop_sum   = {1'b0, drop_cnt_q} + DW'(drops);
        drop_cnt_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];

        // A flush discards the queue and ignores same-cycle inputs entirely.
        if (squash) begin
            mem_d      = mem_q;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            drop_cnt_d = drop_cnt_q;
        end

        in_ready_d = (CW'(DEPTH) - count_d) >= CW'(2);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            drop_cnt_q <= '0;
            in_ready_q <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Data outputs read zero whenever nothing is being presented.
    always_comb begin
        upd_valid = (count_q != '0);
        upd_pc    = upd_valid ? mem_q[rd_ptr_q].pc    : '0;
        upd_tg_pc = upd_valid ? mem_q[rd_ptr_q].tg_pc : '0;
        upd_taken = upd_valid ? mem_q[rd_ptr_q].taken : 1'b0;
        upd_cond  = upd_valid ? mem_q[rd_ptr_q].cond  : 1'b0;
    end

    assign in_ready = in_ready_q;
    assign count    = count_q;
    assign drop_cnt = drop_cnt_q;

endmodule
